elixirchip_es1_spu_op_arbiter: RTL and testbench



---
 rtl/elixirchip_es1_spu_arb_pkg.sv | 24 ++
 rtl/elixirchip_es1_spu_arb_rr.sv | 46 ++++
 rtl/elixirchip_es1_spu_op_arbiter.sv | 145 ++++++++++++++
 tb/tb_elixirchip_es1_spu_op_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elixirchip_es1_spu_arb_pkg.sv
// Shared types, constants and helpers for the SPU shared-resource arbiters.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package elixirchip_es1_spu_arb_pkg;

    // Width of each per-requester grant statistics counter.
    localparam int STAT_BITS = 16;

    // Tag id field is sized for the largest supported requester count (8).
    localparam int TAG_ID_BITS = 3;

    // Ownership record that travels alongside an operation in the shared op.
    typedef struct packed {
        logic                   valid;
        logic [TAG_ID_BITS-1:0] id;
        logic                   clear;
    } tag_t;

    // clog2 that never returns less than 1, so a 1-bit id exists even for 2 requesters.
    function automatic int id_bits(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

endpackage

// File: rtl/elixirchip_es1_spu_arb_rr.sv
// Combinational round-robin grant: lowest valid index at or after rr_ptr wins.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; callers qualify the grant with their own enable.
module elixirchip_es1_spu_arb_rr
    import elixirchip_es1_spu_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_BITS = id_bits(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_BITS-1:0] rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_BITS-1:0] grant_idx,
    output logic               grant_any
);

    logic found_hi;
    logic found_lo;

    // Two passes: first search indices >= rr_ptr, then wrap to the indices below it.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        found_hi  = 1'b0;
        found_lo  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found_hi && valid[i] && (i >= int'(rr_ptr))) begin
                found_hi  = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = ID_BITS'(i);
            end
        end
        if (!found_hi) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found_lo && valid[i]) begin
                    found_lo  = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = ID_BITS'(i);
                end
            end
        end
        grant_any = found_hi | found_lo;
    end

endmodule

// File: rtl/elixirchip_es1_spu_op_arbiter.sv
// Round-robin sharing of one SPU binary-op instance between NUM_REQ requesters.
// Latency: LATENCY cycles from transfer to m_valid (0 = combinational bypass).
// Backpressure: m_ready drives op_cke; low m_ready freezes grants, tags and outputs.
// Optional macro ELIXIRCHIP_ES1_SPU_ARB_STATS_EN adds stat_clear / stat_grant_count.
module elixirchip_es1_spu_op_arbiter
    import elixirchip_es1_spu_arb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int LATENCY   = 3,
    parameter int DATA_BITS = 8,
    parameter int ID_BITS   = id_bits(NUM_REQ)
) (
    input  logic                           reset,
    input  logic                           clk,
    input  logic [NUM_REQ*DATA_BITS-1:0]   s_req_data0,
    input  logic [NUM_REQ*DATA_BITS-1:0]   s_req_data1,
    input  logic [NUM_REQ-1:0]             s_req_clear,
    input  logic [NUM_REQ-1:0]             s_req_valid,
    output logic [NUM_REQ-1:0]             s_req_ready,
    output logic                           op_cke,
    output logic [DATA_BITS-1:0]           op_data0,
    output logic [DATA_BITS-1:0]           op_data1,
    output logic                           op_clear,
    output logic                           op_valid,
    input  logic [DATA_BITS-1:0]           op_result,
    output logic [DATA_BITS-1:0]           m_data,
    output logic [ID_BITS-1:0]             m_id,
    output logic                           m_clear,
    output logic                           m_valid,
    input  logic                           m_ready
`ifdef ELIXIRCHIP_ES1_SPU_ARB_STATS_EN
    ,
    input  logic                           stat_clear,
    output logic [NUM_REQ*STAT_BITS-1:0]   stat_grant_count
`endif
);

    logic [NUM_REQ-1:0] grant;
    logic [ID_BITS-1:0] grant_idx;
    logic               grant_any;
    logic [ID_BITS-1:0] rr_ptr;
    logic               transfer;

    // The shared op and our tag pipe move only when downstream can take a result.
    assign op_cke = m_ready;

    elixirchip_es1_spu_arb_rr #(
        .NUM_REQ (NUM_REQ),
        .ID_BITS (ID_BITS)
    ) u_rr (
        .valid     (s_req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Ready never depends on the requester's own valid beyond the grant decision.
    assign s_req_ready = grant & {NUM_REQ{op_cke}};
    assign transfer    = grant_any & op_cke;
    assign op_valid    = transfer;

    // Steer the granted requester's fields to the op; idle cycles present zeros.
    always_comb begin
        op_data0 = '0;
        op_data1 = '0;
        op_clear = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i] && op_cke) begin
                op_data0 = s_req_data0[i*DATA_BITS +: DATA_BITS];
                op_data1 = s_req_data1[i*DATA_BITS +: DATA_BITS];
                op_clear = s_req_clear[i];
            end
        end
    end

    // Pointer moves just past the last winner so every requester gets a turn.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (transfer) begin
            if (grant_idx == ID_BITS'(NUM_REQ - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_idx + 1'b1;
            end
        end
    end

    // The op owns the data path; the arbiter only labels what comes out of it.
    assign m_data = op_result;

    if (LATENCY == 0) begin : g_bypass
        assign m_valid = transfer;
        assign m_id    = grant_idx;
        assign m_clear = op_clear;
    end else begin : g_tag_pipe
        tag_t tag_in;
        tag_t tag_q [LATENCY];

        // Stage-0 tag records who owns the op presented this cycle.
        always_comb begin
            tag_in       = '0;
            tag_in.valid = transfer;
            tag_in.id    = TAG_ID_BITS'(grant_idx);
            tag_in.clear = op_clear;
        end

        // Tags shift in lockstep with the op; reset drops every in-flight owner.
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int s = 0; s < LATENCY; s++) begin
                    tag_q[s] <= '0;
                end
            end else if (op_cke) begin
                tag_q[0] <= tag_in;
                for (int s = 1; s < LATENCY; s++) begin
                    tag_q[s] <= tag_q[s-1];
                end
            end
        end

        assign m_valid = tag_q[LATENCY-1].valid;
        assign m_id    = ID_BITS'(tag_q[LATENCY-1].id);
        assign m_clear = tag_q[LATENCY-1].clear;
    end

`ifdef ELIXIRCHIP_ES1_SPU_ARB_STATS_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
        logic [STAT_BITS-1:0] cnt_q;

        // Saturating per-requester transfer count; stat_clear beats increment.
        always_ff @(posedge clk) begin
            if (reset || stat_clear) begin
                cnt_q <= '0;
            end else if (transfer && grant[i] && (cnt_q != {STAT_BITS{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign stat_grant_count[i*STAT_BITS +: STAT_BITS] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_elixirchip_es1_spu_op_arbiter.sv
// Bench for the shared-op arbiter with a nand op (CLEAR_DATA = 123) modelled locally.
// Latency: results checked LATENCY cke-cycles after each transfer.
// Backpressure: m_ready is dropped mid-stream to exercise stall behaviour.
module tb_elixirchip_es1_spu_op_arbiter;

    localparam int N  = 2;
    localparam int L  = 3;
    localparam int DW = 8;
    localparam logic [DW-1:0] CLEAR_DATA = 8'd123;

    logic            reset;
    logic            clk;
    logic [N*DW-1:0] s_req_data0;
    logic [N*DW-1:0] s_req_data1;
    logic [N-1:0]    s_req_clear;
    logic [N-1:0]    s_req_valid;
    logic [N-1:0]    s_req_ready;
    logic            op_cke;
    logic [DW-1:0]   op_data0;
    logic [DW-1:0]   op_data1;
    logic            op_clear;
    logic            op_valid;
    logic [DW-1:0]   op_result;
    logic [DW-1:0]   m_data;
    logic [0:0]      m_id;
    logic            m_clear;
    logic            m_valid;
    logic            m_ready;
`ifdef ELIXIRCHIP_ES1_SPU_ARB_STATS_EN
    logic            stat_clear;
    logic [N*16-1:0] stat_grant_count;
`endif

    elixirchip_es1_spu_op_arbiter #(
        .NUM_REQ   (N),
        .LATENCY   (L),
        .DATA_BITS (DW)
    ) dut (
        .reset       (reset),
        .clk         (clk),
        .s_req_data0 (s_req_data0),
        .s_req_data1 (s_req_data1),
        .s_req_clear (s_req_clear),
        .s_req_valid (s_req_valid),
        .s_req_ready (s_req_ready),
        .op_cke      (op_cke),
        .op_data0    (op_data0),
        .op_data1    (op_data1),
        .op_clear    (op_clear),
        .op_valid    (op_valid),
        .op_result   (op_result),
        .m_data      (m_data),
        .m_id        (m_id),
        .m_clear     (m_clear),
        .m_valid     (m_valid),
        .m_ready     (m_ready)
`ifdef ELIXIRCHIP_ES1_SPU_ARB_STATS_EN
        ,
        .stat_clear       (stat_clear),
        .stat_grant_count (stat_grant_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared nand op: L-deep pipe advancing on cke, clear yields CLEAR_DATA.
    logic [DW-1:0] op_pipe [L];
    always @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < L; s++) op_pipe[s] <= '0;
        end else if (op_cke) begin
            op_pipe[0] <= op_clear ? CLEAR_DATA : ~(op_data0 & op_data1);
            for (int s = 1; s < L; s++) op_pipe[s] <= op_pipe[s-1];
        end
    end
    assign op_result = op_pipe[L-1];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: in-flight items with a countdown of remaining cke edges.
    typedef struct {
        int            rem;
        logic [DW-1:0] data;
        int            id;
        logic          clr;
    } item_t;
    typedef struct {
        logic [DW-1:0] d;
        int            id;
        logic          c;
        int            cyc;
    } rec_t;

    item_t fly[$];
    rec_t  log_q[$];
    int    xfer_cyc[$];
    int    mptr = 0;
    int    cyc = 0;
    bit    exp_xfer;
    int    exp_k;
    logic [N-1:0] acc;

    // Compare every cycle at negedge: grant/op drive and result stream.
    always @(negedge clk) begin
        bit            mv;
        item_t         ex;
        logic [DW-1:0] e0, e1;
        exp_xfer = 1'b0;
        exp_k    = 0;
        mv       = 1'b0;
        ex       = '{0, '0, 0, 1'b0};
        if (!reset) begin
            if (m_ready) begin
                for (int o = 0; o < N; o++) begin
                    if (!exp_xfer && s_req_valid[(mptr + o) % N]) begin
                        exp_xfer = 1'b1;
                        exp_k    = (mptr + o) % N;
                    end
                end
            end
            check("s_req_ready", 32'(s_req_ready), exp_xfer ? (32'd1 << exp_k) : 32'd0);
            check("op_valid", 32'(op_valid), 32'(exp_xfer));
            check("op_cke", 32'(op_cke), 32'(m_ready));
            if (exp_xfer) begin
                e0 = s_req_data0[exp_k*DW +: DW];
                e1 = s_req_data1[exp_k*DW +: DW];
                check("op_data0", 32'(op_data0), 32'(e0));
                check("op_data1", 32'(op_data1), 32'(e1));
                check("op_clear", 32'(op_clear), 32'(s_req_clear[exp_k]));
                xfer_cyc.push_back(cyc);
            end else begin
                check("op_idle_data0", 32'(op_data0), 32'd0);
                check("op_idle_clear", 32'(op_clear), 32'd0);
            end
        end
        foreach (fly[i]) if (fly[i].rem == 0) begin mv = 1'b1; ex = fly[i]; end
        check("m_valid", 32'(m_valid), 32'(mv));
        if (mv) begin
            check("m_data", 32'(m_data), 32'(ex.data));
            check("m_id", 32'(m_id), ex.id);
            check("m_clear", 32'(m_clear), 32'(ex.clr));
        end
        if (m_valid === 1'b1 && m_ready === 1'b1)
            log_q.push_back('{m_data, int'(m_id), m_clear, cyc});
    end

    // Model state update at each clock edge using the decision made at negedge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        acc <= s_req_valid & s_req_ready;
        if (reset) begin
            fly.delete();
            mptr = 0;
        end else if (m_ready) begin
            if (fly.size() > 0 && fly[0].rem == 0) void'(fly.pop_front());
            foreach (fly[i]) fly[i].rem = fly[i].rem - 1;
            if (exp_xfer) begin
                fly.push_back('{L - 1,
                    s_req_clear[exp_k] ? CLEAR_DATA
                                       : ~(s_req_data0[exp_k*DW +: DW] & s_req_data1[exp_k*DW +: DW]),
                    exp_k, s_req_clear[exp_k]});
                mptr = (exp_k + 1) % N;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        s_req_valid = '0;
        s_req_clear = '0;
        m_ready     = 1'b1;
        step(2);
        reset = 1'b0;
        log_q.delete();
        xfer_cyc.delete();
    endtask

    task automatic chk_log(input int idx, input logic [DW-1:0] d, input int id, input logic c);
        if (idx < log_q.size()) begin
            check($sformatf("log%0d_data", idx), 32'(log_q[idx].d), 32'(d));
            check($sformatf("log%0d_id", idx), log_q[idx].id, id);
            check($sformatf("log%0d_clear", idx), 32'(log_q[idx].c), 32'(c));
        end else begin
            check($sformatf("log%0d_present", idx), 32'd0, 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int i;
        s_req_data0 = '0;
        s_req_data1 = '0;
`ifdef ELIXIRCHIP_ES1_SPU_ARB_STATS_EN
        stat_clear = 1'b0;
`endif
        do_reset();

        // Reset state.
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_id", 32'(m_id), 32'd0);
        check("rst_m_clear", 32'(m_clear), 32'd0);

        // Single requester, back-to-back.
        s_req_valid = 2'b01;
        s_req_data0[7:0] = 8'h00; s_req_data1[7:0] = 8'h00; step(1);
        s_req_data0[7:0] = 8'hfe; s_req_data1[7:0] = 8'hff; step(1);
        s_req_data0[7:0] = 8'h5a; s_req_data1[7:0] = 8'ha5; step(1);
        s_req_valid = '0;
        step(6);
        check("single_count", log_q.size(), 3);
        chk_log(0, 8'hff, 0, 1'b0);
        chk_log(1, 8'h01, 0, 1'b0);
        chk_log(2, 8'hff, 0, 1'b0);
        if (log_q.size() == 3 && xfer_cyc.size() == 3) begin
            check("single_latency", log_q[0].cyc - xfer_cyc[0], 3);
            check("single_gap1", log_q[1].cyc - log_q[0].cyc, 1);
            check("single_gap2", log_q[2].cyc - log_q[1].cyc, 1);
        end else begin
            check("single_xfers", xfer_cyc.size(), 3);
        end

        // Contention: alternation starting at requester 0.
        do_reset();
        s_req_data0 = {8'hff, 8'h80};
        s_req_data1 = {8'hff, 8'h80};
        s_req_valid = 2'b11;
        step(6);
        s_req_valid = '0;
        step(6);
        check("cont_xfers", xfer_cyc.size(), 6);
        check("cont_count", log_q.size(), 6);
        for (int k = 0; k < 6; k++)
            chk_log(k, (k % 2 == 0) ? 8'h7f : 8'h00, k % 2, 1'b0);

        // Backpressure: 4-cycle stall mid-stream, distinct data per transfer.
        do_reset();
        s_req_data1[7:0] = 8'hff;
        i = 0;
        for (int c = 0; c < 40 && i < 8; c++) begin
            m_ready          = !(c >= 3 && c < 7);
            s_req_data0[7:0] = 8'(i);
            s_req_valid      = 2'b01;
            step(1);
            if (acc[0]) i++;
        end
        s_req_valid = '0;
        m_ready     = 1'b1;
        step(6);
        check("bp_count", log_q.size(), 8);
        for (int k = 0; k < 8; k++) chk_log(k, ~8'(k), 0, 1'b0);

        // Clear transaction from requester 1.
        do_reset();
        s_req_data0 = {8'h99, 8'h00};
        s_req_data1 = {8'h99, 8'h00};
        s_req_clear = 2'b10;
        s_req_valid = 2'b10;
        step(1);
        s_req_valid = '0;
        s_req_clear = '0;
        step(6);
        check("clear_count", log_q.size(), 1);
        chk_log(0, 8'h7b, 1, 1'b1);
        check("clear_after_idle", 32'(m_valid), 32'd0);

        // Reset with three operations in flight.
        do_reset();
        s_req_data0 = {8'hff, 8'h80};
        s_req_data1 = {8'hff, 8'h80};
        s_req_valid = 2'b11;
        step(3);
        s_req_valid = '0;
        reset       = 1'b1;
        step(1);
        check("midrst_m_valid", 32'(m_valid), 32'd0);
        step(1);
        reset = 1'b0;
        log_q.delete();
        step(6);
        check("midrst_stale", log_q.size(), 0);
        s_req_valid = 2'b11;
        #2;
        check("midrst_first_grant", 32'(s_req_ready), 32'd1);
        step(1);
        s_req_valid = '0;
        step(5);

`ifdef ELIXIRCHIP_ES1_SPU_ARB_STATS_EN
        // Grant statistics.
        do_reset();
        s_req_valid = 2'b01; step(5);
        s_req_valid = 2'b10; step(3);
        s_req_valid = '0;    step(1);
        check("stat_req0", 32'(stat_grant_count[15:0]), 32'd5);
        check("stat_req1", 32'(stat_grant_count[31:16]), 32'd3);
        stat_clear = 1'b1; step(1);
        stat_clear = 1'b0; step(1);
        check("stat_clr0", 32'(stat_grant_count[15:0]), 32'd0);
        check("stat_clr1", 32'(stat_grant_count[31:16]), 32'd0);
        step(4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
